// File: rtl/sweep_ctrl_pkg.sv
// Shared definitions for the sweep sequencer: state encoding and the
// default datapath widths used by the top module and its bench.
package sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEEK = 3'd1,
    UP   = 3'd2,
    DOWN = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_SW_W  = 8;

endpackage

// File: rtl/sweep_ctrl.sv
// Sweep sequencer that steers an external up/down counter: it seeks the
// count to the lower bound, then ping-pongs between the bounds for a
// programmed number of round trips and pulses done at the end.
module sweep_ctrl
  import sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SW_W  = DEF_SW_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [SW_W-1:0]  sweeps,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_en,
  output logic             up_down,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SW_W-1:0]  sweep_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [SW_W-1:0]  sw_q, sw_d;
  logic [SW_W-1:0]  sweep_cnt_q, sweep_cnt_d;
  logic             err_q, err_d;
  logic [SW_W-1:0]  sweep_inc;
  logic             cfg_ok;

  assign sweep_inc = sweep_cnt_q + SW_W'(1);
  assign cfg_ok    = (lo < hi) && (sweeps != '0);

  // Next-state logic and same-cycle counter controls; an abort in an
  // active state overrides whatever the state would otherwise request.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    sw_d        = sw_q;
    sweep_cnt_d = sweep_cnt_q;
    err_d       = 1'b0;
    cnt_en      = 1'b0;
    up_down     = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            lo_d        = lo;
            hi_d        = hi;
            sw_d        = sweeps;
            sweep_cnt_d = '0;
            state_d     = SEEK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEEK: begin
        cnt_en  = (count != lo_q);
        up_down = (count < lo_q);
        if (count == lo_q) begin
          state_d = UP;
        end
      end
      UP: begin
        cnt_en  = 1'b1;
        up_down = (count != hi_q);
        if (count == hi_q) begin
          state_d = DOWN;
        end
      end
      DOWN: begin
        if (count == lo_q) begin
          sweep_cnt_d = sweep_inc;
          if (sweep_inc == sw_q) begin
            cnt_en  = 1'b0;
            state_d = DONE;
          end else begin
            cnt_en  = 1'b1;
            up_down = 1'b1;
            state_d = UP;
          end
        end else begin
          cnt_en  = 1'b1;
          up_down = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && (state_q == SEEK || state_q == UP || state_q == DOWN)) begin
      cnt_en      = 1'b0;
      sweep_cnt_d = sweep_cnt_q;
      state_d     = IDLE;
    end
  end

  // State, latched configuration, round-trip counter and error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      sw_q        <= '0;
      sweep_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      sw_q        <= sw_d;
      sweep_cnt_q <= sweep_cnt_d;
      err_q       <= err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign sweep_cnt = sweep_cnt_q;

endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Sequencer for the team's W-bit up/down counter datapath. It drives the counter's direction (`up_down`) and a count enable (`cnt_en`), and observes the counter's registered `count`. It walks the count to a programmed lower bound, then ping-pongs between lower and upper bounds for a programmed number of round trips, and reports done. It sits beside the counter; `count` is a registered counter output, so combinational outputs from `count` form no loop.

## Interface
- `WIDTH`, 4: counter width.
- `SW_W`, 8: width of sweep count and sweep counter.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: begin a run; sampled only in IDLE.
- `abort` input 1: terminate the run; sampled in any non-IDLE state.
- `lo` input WIDTH: lower bound, unsigned; latched at start.
- `hi` input WIDTH: upper bound, unsigned; latched at start.
- `sweeps` input SW_W: number of round trips lo→hi→lo; latched at start.
- `count` input WIDTH: current counter value.
- `cnt_en` output 1: counter steps ±1 on the next edge when 1 (combinational).
- `up_down` output 1: 1 = increment, 0 = decrement (combinational).
- `busy` output 1: state ≠ IDLE.
- `done` output 1: one-cycle pulse at run completion.
- `err` output 1: one-cycle pulse on a rejected start.
- `sweep_cnt` output SW_W: completed round trips in the current or last run.

## Operation
- States: IDLE, SEEK, UP, DOWN, DONE.
- All registers (state, `lo_q`, `hi_q`, `sw_q`, `sweep_cnt`, `err`) reset asynchronously: state=IDLE, `sweep_cnt`=0, `err`=0.
- Reset-derived output values: `cnt_en`=0, `up_down`=1, `busy`=0, `done`=0, `err`=0.

**IDLE**
- Outputs: `cnt_en`=0, `up_down`=1.
- On `start` with `lo<hi` and `sweeps≠0`: latch the config, clear `sweep_cnt`, go to SEEK.
- On `start` with an invalid config: `err`=1 on the next cycle; stay in IDLE; latched values unchanged.

**SEEK**
- Outputs: `cnt_en`=(`count`≠`lo_q`), `up_down`=(`count`<`lo_q`).
- When `count`==`lo_q`: go to UP. No step occurs in that cycle.

**UP**
- Outputs: `cnt_en`=1, `up_down`=(`count`≠`hi_q`).
- When `count`==`hi_q`: go to DOWN. The counter steps down in this same cycle.

**DOWN**
- When `count`==`lo_q`: `sweep_cnt` increments.
  - If the new value equals `sw_q`: go to DONE with `cnt_en`=0.
  - Otherwise: go to UP with `cnt_en`=1, `up_down`=1.
- Else: `cnt_en`=1, `up_down`=0.

**DONE**
- Outputs: `cnt_en`=0, `done`=1.
- Next state: IDLE.

**Other rules**
- `abort` in SEEK/UP/DOWN: `cnt_en` is forced to 0 in that cycle; next state IDLE; no `done`; `sweep_cnt` holds.
- `start` while busy is ignored. Config input changes while busy are ignored.
- The counter never wraps: direction reverses at `hi_q` ≤ 2^WIDTH−1 and at `lo_q` ≥ 0. `hi`=2^WIDTH−1 and `lo`=0 are legal.
- `sweep_cnt` saturation is unreachable, since `sweep_cnt` ≤ `sweeps`.

## Timing
- Start accepted at edge E0; SEEK is active from cycle 1.
- Count c0 at SEEK entry: SEEK lasts |c0−lo|+1 cycles.
- Each round trip takes 2·(hi−lo) enabled steps.
- `done` is high in exactly cycle start+|c0−lo|+2·N·(hi−lo)+3; `busy` falls on the following cycle.
- `done` and `err` are registered/Moore. `cnt_en` and `up_down` are same-cycle functions of state and `count`.
- Reset mid-run: immediate IDLE outputs, `sweep_cnt`=0.

## Structure
- A shared package holds:
  - the state enum (IDLE, SEEK, UP, DOWN, DONE);
  - the default `WIDTH`/`SW_W` constants.
- Single module, no sub-module.
- The bench pairs it with a WIDTH-bit up/down counter model that has an enable, reset by the same `reset`.

## Test plan
- Reset mid-run (count mid-sweep): outputs immediately `cnt_en`=0, `up_down`=1, `busy`=0, `sweep_cnt`=0.
- Counter at 0; start with lo=2, hi=5, sweeps=2 at cycle 0:
  - count sequence 0,1,2,2,3,4,5,4,3,2,3,4,5,4,3,2;
  - `done` pulses in cycle 17; `sweep_cnt`=2; count stays at 2.
- Counter at 9 (WIDTH=4); start with lo=3, hi=15, sweeps=1:
  - SEEK counts down 9→3;
  - reversal at 15 with no wrap to 0;
  - `done` fires after 24 enabled UP/DOWN steps.
- Start with lo=5, hi=5 (or sweeps=0): `err`=1 for one cycle; `busy` stays 0; `cnt_en` stays 0.
- `abort` in the first DOWN of a 3-sweep run:
  - `cnt_en`=0 that cycle;
  - IDLE next cycle;
  - no `done`; `sweep_cnt`=0.
- `start` pulsed with new config during UP: ignored; the run completes with the original bounds and count.
